config_tp_ram_loader: RTL and testbench

CONFIG_TP_RAM_LOADER -- requirements
Module: config_tp_ram_loader

---
 rtl/config_tp_ram_loader.sv | 143 ++++++++++++++
 tb/tb_config_tp_ram_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/config_tp_ram_loader.sv
// config_tp_ram_loader: packs a byte stream little-endian into 32-bit words
// and writes them through RAM port 2, starting at base_addr for word_count
// words. Define RAM_LOADER_CHECKSUM_EN to accumulate a mod-2^32 sum of the
// written words on the checksum port; otherwise checksum is tied to zero.
module config_tp_ram_loader #(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] ram_address2,
  output logic [3:0]        ram_byteenable2,
  output logic              ram_chipselect2,
  output logic              ram_write2,
  output logic              ram_clken2,
  output logic [31:0]       ram_writedata2,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remain;
  logic [1:0]        lane;
  logic [7:0]        b0, b1, b2;
  logic              xfer;
  logic              launch;
  logic              wr_go;

  assign s_ready = (state == COLLECT);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign xfer    = s_valid & s_ready;
  // abort beats start in the same IDLE cycle
  assign launch  = (state == IDLE) && start && !abort;
  // 4th byte of a word accepted (and not cancelled): next cycle is WRITE
  assign wr_go   = (state == COLLECT) && xfer && (lane == 2'd3) && !abort;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch) state_nxt = (word_count == '0) ? DONE : COLLECT;
      COLLECT: if (abort) state_nxt = IDLE;
               else if (wr_go) state_nxt = WRITE;
      WRITE:   if (abort) state_nxt = IDLE;
               else if (remain == CNT_W'(1)) state_nxt = DONE;
               else state_nxt = COLLECT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // address/count tracking and byte-lane assembly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr   <= '0;
      remain <= '0;
      lane   <= '0;
      b0     <= '0;
      b1     <= '0;
      b2     <= '0;
    end else begin
      unique case (state)
        IDLE: if (launch) begin
          addr   <= base_addr;
          remain <= word_count;
          lane   <= '0;
        end
        COLLECT: begin
          if (abort) lane <= '0;            // drop the partial word
          else if (xfer) begin
            lane <= lane + 2'd1;            // wraps to 0 after the 4th byte
            unique case (lane)
              2'd0:    b0 <= s_data;
              2'd1:    b1 <= s_data;
              2'd2:    b2 <= s_data;
              default: ;                    // 4th byte goes straight to writedata
            endcase
          end
        end
        WRITE: begin
          addr   <= addr + ADDR_W'(1);      // wraps mod 2^ADDR_W
          remain <= remain - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // registered RAM port: strobes high only during the WRITE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_address2    <= '0;
      ram_writedata2  <= '0;
      ram_byteenable2 <= '0;
      ram_chipselect2 <= 1'b0;
      ram_write2      <= 1'b0;
      ram_clken2      <= 1'b1;
    end else begin
      ram_clken2      <= 1'b1;
      ram_chipselect2 <= wr_go;
      ram_write2      <= wr_go;
      ram_byteenable2 <= {4{wr_go}};
      if (wr_go) begin
        ram_address2   <= addr;
        ram_writedata2 <= {s_data, b2, b1, b0};
      end
    end
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [31:0] sum;

  // running sum of words as they are written; held through DONE/IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            sum <= '0;
    else if (launch)         sum <= '0;
    else if (state == WRITE) sum <= sum + ram_writedata2;
  end

  assign checksum = sum;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_config_tp_ram_loader.sv
// Randomized bench for config_tp_ram_loader. Expected writes are derived
// from the accepted byte stream: every 4 bytes form one little-endian word
// at base+i mod 2^13; checksum is the mod-2^32 sum when the macro is on.
module tb_config_tp_ram_loader;
  localparam int ADDR_W = 13;
  localparam int CNT_W  = 14;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              abort = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [ADDR_W-1:0] ram_address2;
  logic [3:0]        ram_byteenable2;
  logic              ram_chipselect2, ram_write2, ram_clken2;
  logic [31:0]       ram_writedata2;
  logic              busy, done;
  logic [31:0]       checksum;

  config_tp_ram_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ram_address2(ram_address2), .ram_byteenable2(ram_byteenable2),
    .ram_chipselect2(ram_chipselect2), .ram_write2(ram_write2), .ram_clken2(ram_clken2),
    .ram_writedata2(ram_writedata2), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_srdy"}, 32'(s_ready), 0);
    chk({tag, "_cs"},   32'(ram_chipselect2), 0);
    chk({tag, "_wr"},   32'(ram_write2), 0);
    chk({tag, "_be"},   32'(ram_byteenable2), 0);
    chk({tag, "_addr"}, 32'(ram_address2), 0);
    chk({tag, "_data"}, ram_writedata2, 0);
    chk({tag, "_clken"}, 32'(ram_clken2), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ck"},   checksum, 0);
  endtask

  logic [ADDR_W-1:0] obs_addr[$];
  logic [31:0]       obs_data[$];
  logic [7:0]        acc[$];
  int                obs_done;
  int                done_cyc;

  // One load with random (or sequential 1,2,3..) bytes; vpct = s_valid %.
  task automatic run_load(input logic [ADDR_W-1:0] base, input int cnt, input int vpct,
                          input bit seq, input bit inj);
    bit fourth_prev;
    int post;
    logic [31:0] sum, w;
    logic [ADDR_W-1:0] ea;
    obs_addr.delete(); obs_data.delete(); acc.delete();
    obs_done = 0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = CNT_W'(cnt); s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    fourth_prev = 1'b0; post = 0;
    for (int cyc = 0; cyc < 3000 && post < 3; cyc++) begin
      chk("wr_lat", 32'(ram_write2), 32'(fourth_prev));
      if (ram_write2) begin
        obs_addr.push_back(ram_address2);
        obs_data.push_back(ram_writedata2);
        chk("wr_be", 32'(ram_byteenable2), 32'hF);
        chk("wr_cs", 32'(ram_chipselect2), 1);
        chk("wr_clken", 32'(ram_clken2), 1);
      end else begin
        chk("idle_cs", 32'(ram_chipselect2), 0);
      end
      if (done) begin
        obs_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (obs_done > 0) post++;
      start = inj && (cyc == 3);
      if (start) begin
        base_addr = base + ADDR_W'(100);
        word_count = CNT_W'(5);
      end
      s_valid = ($urandom_range(99) < vpct);
      s_data  = seq ? 8'(acc.size() + 1) : 8'($urandom);
      fourth_prev = 1'b0;
      if (s_valid && s_ready) begin
        acc.push_back(s_data);
        fourth_prev = (acc.size() % 4 == 0);
      end
      @(negedge clk);
    end
    start = 1'b0; s_valid = 1'b0;
    chk("done_cnt", 32'(obs_done), 1);
    chk("hs_cnt", 32'(acc.size()), 32'(4 * cnt));
    chk("wr_cnt", 32'(obs_addr.size()), 32'(cnt));
    sum = '0;
    for (int i = 0; i < cnt && i < obs_addr.size() && 4 * i + 3 < acc.size(); i++) begin
      w  = {acc[4*i+3], acc[4*i+2], acc[4*i+1], acc[4*i]};
      ea = base + ADDR_W'(i);
      sum += w;
      chk("wr_addr", 32'(obs_addr[i]), 32'(ea));
      chk("wr_data", obs_data[i], w);
    end
    chk("busy_end", 32'(busy), 0);
`ifdef RAM_LOADER_CHECKSUM_EN
    chk("checksum", checksum, sum);
`else
    chk("checksum", checksum, 32'h0);
`endif
  endtask

  // drive 4 back-to-back bytes lo..lo+3 from COLLECT; returns at WRITE cycle
  task automatic feed4(input logic [7:0] lo);
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_data = lo + 8'(k);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #12;
    chk_rst("rst");
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    // sequential bytes 01..08, two words
    run_load(13'h010, 2, 100, 1'b1, 1'b0);
    if (obs_data.size() == 2) begin
      chk("d37_w0", obs_data[0], 32'h04030201);
      chk("d37_w1", obs_data[1], 32'h08070605);
      chk("d37_a1", 32'(obs_addr[1]), 32'h011);
    end else chk("d37_size", 32'(obs_data.size()), 2);
`ifdef RAM_LOADER_CHECKSUM_EN
    chk("d37_ck", checksum, 32'h0C0A0806);
`endif

    // address wrap
    run_load(13'h1FFF, 2, 70, 1'b0, 1'b0);
    if (obs_addr.size() == 2) begin
      chk("wrap_a0", 32'(obs_addr[0]), 32'h1FFF);
      chk("wrap_a1", 32'(obs_addr[1]), 32'h0000);
    end else chk("wrap_size", 32'(obs_addr.size()), 2);

    // zero-length load: done right after start, no strobe
    run_load(13'h055, 0, 100, 1'b0, 1'b0);
    chk("zero_done_cyc", 32'(done_cyc), 0);

    // abort after 2 of 4 bytes
    @(negedge clk); start = 1'b1; base_addr = 13'h020; word_count = 14'd2;
    @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 8'hAA;
    @(negedge clk); s_data = 8'hBB;
    @(negedge clk); s_valid = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_srdy", 32'(s_ready), 0);
    for (int k = 0; k < 3; k++) begin
      chk("ab_wr", 32'(ram_write2), 0);
      chk("ab_done", 32'(done), 0);
      @(negedge clk);
    end
    run_load(13'h030, 1, 100, 1'b1, 1'b0);
    if (obs_data.size() == 1) chk("ab_reload", obs_data[0], 32'h04030201);

    // start and abort together in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1; base_addr = 13'h5; word_count = 14'd1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);

    // abort during WRITE: write completes, no done
    @(negedge clk); start = 1'b1; base_addr = 13'h040; word_count = 14'd2;
    @(negedge clk); start = 1'b0;
    feed4(8'h11);
    chk("aw_wr", 32'(ram_write2), 1);
    chk("aw_data", ram_writedata2, 32'h14131211);
    chk("aw_addr", 32'(ram_address2), 32'h040);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("aw_busy", 32'(busy), 0);
    chk("aw_done", 32'(done), 0);
    @(negedge clk);
    chk("aw_done2", 32'(done), 0);

    // random loads, one with a start injected mid-load
    run_load(13'($urandom), 3, 50, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++)
      run_load(13'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(30, 100)), 1'b0, 1'b0);

    // reset during WRITE clears outputs asynchronously
    @(negedge clk); start = 1'b1; base_addr = 13'h077; word_count = 14'd1;
    @(negedge clk); start = 1'b0;
    feed4(8'h21);
    chk("rw_wr_before", 32'(ram_write2), 1);
    #1 reset_n = 1'b0;
    #1 chk_rst("rw");
    @(negedge clk); reset_n = 1'b1;
    run_load(13'h100, 1, 100, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
